// File: rtl/imem_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : imem_loader_pkg
//  Brief   : Shared constants for the instruction-memory loader: default
//            memory depth, header width and loader state encodings.
//  Rev     : 1.0  initial release
// ============================================================================
package imem_loader_pkg;

    // Instruction memory depth in 32-bit words; also sizes the memory itself
    localparam int unsigned c_imem_depth = 1024;

    // Width of the little-endian word-count header
    localparam int unsigned c_hdr_w = 16;

    typedef enum logic [2:0] {
        ST_HDR0  = 3'd0,
        ST_HDR1  = 3'd1,
        ST_DATA  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERR   = 3'd5
    } ldr_state_t;

    // States in which the loader takes bytes from the stream
    function automatic logic accepts_bytes(input ldr_state_t s);
        return (s == ST_HDR0) || (s == ST_HDR1) || (s == ST_DATA);
    endfunction

    // States in which a load is considered in progress
    function automatic logic is_busy(input ldr_state_t s);
        return (s == ST_HDR1) || (s == ST_DATA) || (s == ST_WRITE);
    endfunction

endpackage
`default_nettype wire

// File: rtl/imem_loader_byte_packer.sv
`default_nettype none
// ============================================================================
//  Module  : imem_loader_byte_packer  (byte_packer)
//  Brief   : Assembles four little-endian stream bytes into a 32-bit word.
//            The first byte ends up in word[7:0].
//  Rev     : 1.0  initial release
// ============================================================================
module imem_loader_byte_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clr,
    input  logic        i_shift,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic        o_word_complete
);

    logic [1:0]  r_cnt;
    logic [31:0] r_word;

    // Shift bytes in from the top so the earliest byte lands in the low lane
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= 2'd0;
            r_word <= 32'd0;
        end else if (i_clr) begin
            r_cnt  <= 2'd0;
        end else if (i_shift) begin
            r_cnt  <= r_cnt + 2'd1;
            r_word <= {i_byte, r_word[31:8]};
        end
    end

    assign o_word          = r_word;
    assign o_word_complete = i_shift && (r_cnt == 2'd3);

endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
//  Module  : imem_loader
//  Brief   : Receives a byte stream (16-bit word count N, then N little-endian
//            32-bit words) and writes the words to instruction memory at
//            consecutive word-aligned byte addresses starting at 0.
//  Rev     : 1.0  initial release
// ============================================================================
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned DEPTH = c_imem_depth
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_byte,
    output logic        in_ready,
    output logic        we,
    output logic [31:0] waddr,
    output logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        error
);

    // Index must be able to hold DEPTH itself so the final compare never wraps
    localparam int unsigned c_idx_w = $clog2(DEPTH + 1);
    localparam logic [31:0] c_depth = 32'(DEPTH);

    ldr_state_t          r_state;
    ldr_state_t          w_state_nxt;
    logic [c_hdr_w-1:0]  r_n;
    logic [c_idx_w-1:0]  r_idx;
    logic [c_idx_w-1:0]  w_idx_inc;
    logic [c_hdr_w-1:0]  w_n_full;
    logic                w_n_bad;
    logic                w_last;
    logic                w_xfer;
    logic                r_in_ready;
    logic                r_we;
    logic [31:0]         r_waddr;
    logic                r_busy;
    logic                r_done;
    logic                r_error;
    logic [31:0]         w_word;
    logic                w_word_complete;

    assign w_xfer    = in_valid && r_in_ready;
    assign w_n_full  = {in_byte, r_n[7:0]};
    assign w_n_bad   = (w_n_full == '0) || ({16'd0, w_n_full} > c_depth);
    assign w_idx_inc = r_idx + 1'b1;
    assign w_last    = (32'(w_idx_inc) == 32'(r_n));

    imem_loader_byte_packer u_byte_packer (
        .clk             (clk),
        .rst             (rst),
        .i_clr           (r_state != ST_DATA),
        .i_shift         (w_xfer && (r_state == ST_DATA)),
        .i_byte          (in_byte),
        .o_word          (w_word),
        .o_word_complete (w_word_complete)
    );

    // Next-state decode; outputs are registered from the next state below
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_HDR0:  if (w_xfer) w_state_nxt = ST_HDR1;
            ST_HDR1:  if (w_xfer) w_state_nxt = w_n_bad ? ST_ERR : ST_DATA;
            ST_DATA:  if (w_word_complete) w_state_nxt = ST_WRITE;
            ST_WRITE: w_state_nxt = w_last ? ST_DONE : ST_DATA;
            ST_DONE,
            ST_ERR:   if (start) w_state_nxt = ST_HDR0;
            default:  w_state_nxt = ST_HDR0;
        endcase
    end

    // State, header/index bookkeeping and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_HDR0;
            r_n        <= '0;
            r_idx      <= '0;
            r_in_ready <= 1'b0;
            r_we       <= 1'b0;
            r_waddr    <= 32'd0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= accepts_bytes(w_state_nxt);
            r_busy     <= is_busy(w_state_nxt);
            r_done     <= (w_state_nxt == ST_DONE);
            r_error    <= (w_state_nxt == ST_ERR);
            r_we       <= (w_state_nxt == ST_WRITE);
            // The write address is the index before it advances in WRITE
            r_waddr    <= (w_state_nxt == ST_WRITE) ? 32'({r_idx, 2'b00}) : 32'd0;

            case (r_state)
                ST_HDR0: if (w_xfer) r_n <= {8'd0, in_byte};
                ST_HDR1: if (w_xfer) begin
                    r_n   <= w_n_full;
                    r_idx <= '0;
                end
                ST_WRITE: r_idx <= w_idx_inc;
                ST_DONE,
                ST_ERR:   if (start) r_idx <= '0;
                default: ;
            endcase
        end
    end

    assign in_ready = r_in_ready;
    assign we       = r_we;
    assign waddr    = r_waddr;
    // The packer holds the finished word steady for the whole WRITE cycle
    assign wdata    = r_we ? w_word : 32'd0;
    assign busy     = r_busy;
    assign done     = r_done;
    assign error    = r_error;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
//  Module  : tb_imem_loader
//  Brief   : Self-checking bench for imem_loader: a byte-level model predicts
//            each write and pushes it to a scoreboard queue; every cycle the
//            write port is compared against the model.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_imem_loader;

    localparam int unsigned DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_byte;
    logic        in_ready;
    logic        we;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        error;

    imem_loader #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_valid (in_valid),
        .in_byte  (in_byte),
        .in_ready (in_ready),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .busy     (busy),
        .done     (done),
        .error    (error)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic [7:0] h0;
        logic [7:0] h1;
        logic       exp_err;
        int         n;
    } hdr_vec_t;

    int          checks;
    int          errors;
    wr_t         sb_q[$];
    wr_t         seen_q[$];
    int          acc;
    int          widx;
    logic [31:0] wbuf;
    logic        exp_we;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        acc    = 0;
        widx   = 0;
        wbuf   = 32'd0;
        exp_we = 1'b0;
        sb_q.delete();
        seen_q.delete();
    endtask

    // Per-cycle comparison of the write port against the model
    task automatic check_cycle();
        check("we", 32'(we), 32'(exp_we));
        if (we) begin
            check("in_ready_in_write", 32'(in_ready), 32'd0);
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %h data %h expected no write", waddr, wdata);
            end else begin
                wr_t e;
                e = sb_q.pop_front();
                check("waddr", waddr, e.addr);
                check("wdata", wdata, e.data);
                seen_q.push_back({waddr, wdata});
            end
        end else begin
            check("waddr_idle", waddr, 32'd0);
            check("wdata_idle", wdata, 32'd0);
        end
    endtask

    // One clock: drive at the falling edge, predict, then check after the rise
    task automatic step(input logic v, input logic [7:0] b, input logic st, output logic accepted);
        logic xfer;
        in_valid = v;
        in_byte  = b;
        start    = st;
        xfer     = v && in_ready;
        exp_we   = 1'b0;
        if (xfer) begin
            if (acc >= 2) begin
                int pos;
                pos = (acc - 2) % 4;
                wbuf[pos*8 +: 8] = b;
                if (pos == 3) begin
                    sb_q.push_back({32'(widx * 4), wbuf});
                    widx++;
                    exp_we = 1'b1;
                end
            end
            acc++;
        end
        accepted = xfer;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        start    = 1'b0;
        check_cycle();
    endtask

    task automatic idle(input logic st);
        logic unused_ok;
        step(1'b0, 8'h00, st, unused_ok);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic gap, input logic st);
        logic ok;
        int   tries;
        ok    = 1'b0;
        tries = 0;
        while (!ok && tries < 64) begin
            logic v;
            v = gap ? ($urandom_range(0, 2) != 0) : 1'b1;
            step(v, b, st, ok);
            tries++;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_byte_timeout: got no transfer of %h expected one within 64 cycles", b);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_we", 32'(we), 32'd0);
        check("rst_waddr", waddr, 32'd0);
        check("rst_wdata", wdata, 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        model_clear();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("in_ready_after_rst", 32'(in_ready), 32'd1);
        check("busy_idle_hdr0", 32'(busy), 32'd0);
    endtask

    task automatic check_done(input int n);
        check("done", 32'(done), 32'd1);
        check("in_ready_done", 32'(in_ready), 32'd0);
        check("busy_done", 32'(busy), 32'd0);
        check("write_count", 32'(seen_q.size()), 32'(n));
        check("sb_empty", 32'(sb_q.size()), 32'd0);
    endtask

    task automatic check_rearmed();
        check("rearm_in_ready", 32'(in_ready), 32'd1);
        check("rearm_done", 32'(done), 32'd0);
        check("rearm_error", 32'(error), 32'd0);
        check("rearm_busy", 32'(busy), 32'd0);
    endtask

    task automatic run_nominal(input logic gap, input logic start_mid);
        logic [7:0] bytes [10];
        bytes = '{8'h02, 8'h00, 8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h08};
        do_reset();
        for (int i = 0; i < 10; i++) begin
            send_byte(bytes[i], gap, start_mid && (i == 4));
            if (start_mid && i == 4) check("busy_after_start_mid", 32'(busy), 32'd1);
        end
        idle(1'b0);
        check_done(2);
        if (seen_q.size() == 2) begin
            check("nom_addr0", seen_q[0].addr, 32'h0);
            check("nom_data0", seen_q[0].data, 32'h05000820);
            check("nom_addr1", seen_q[1].addr, 32'h4);
            check("nom_data1", seen_q[1].data, 32'h08000000);
        end
    endtask

    hdr_vec_t vecs [5];

    initial begin
        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_byte  = 8'h00;
        model_clear();
        @(negedge clk);

        vecs[0] = '{h0: 8'h00, h1: 8'h00, exp_err: 1'b1, n: 0};
        vecs[1] = '{h0: 8'h01, h1: 8'h04, exp_err: 1'b1, n: 1025};
        vecs[2] = '{h0: 8'hFF, h1: 8'hFF, exp_err: 1'b1, n: 65535};
        vecs[3] = '{h0: 8'h01, h1: 8'h00, exp_err: 1'b0, n: 1};
        vecs[4] = '{h0: 8'h05, h1: 8'h00, exp_err: 1'b0, n: 5};

        // Header legality table
        for (int v = 0; v < 5; v++) begin
            do_reset();
            send_byte(vecs[v].h0, 1'b0, 1'b0);
            check("busy_hdr1", 32'(busy), 32'd1);
            send_byte(vecs[v].h1, 1'b0, 1'b0);
            check("error_after_hdr", 32'(error), 32'(vecs[v].exp_err));
            if (vecs[v].exp_err) begin
                check("err_in_ready", 32'(in_ready), 32'd0);
                check("err_busy", 32'(busy), 32'd0);
                idle(1'b0);
                idle(1'b0);
                check("err_no_write", 32'(seen_q.size()), 32'd0);
            end else begin
                for (int w = 0; w < vecs[v].n; w++)
                    for (int k = 0; k < 4; k++)
                        send_byte(8'($urandom_range(0, 255)), 1'b1, 1'b0);
                idle(1'b0);
                check_done(vecs[v].n);
            end
            idle(1'b1);
            check_rearmed();
        end

        // Nominal, with random gaps, and with start pulsed during DATA
        run_nominal(1'b0, 1'b0);
        run_nominal(1'b1, 1'b0);
        run_nominal(1'b1, 1'b1);

        // Reset after two data bytes, then a fresh one-word load
        do_reset();
        send_byte(8'h02, 1'b0, 1'b0);
        send_byte(8'h00, 1'b0, 1'b0);
        send_byte(8'h11, 1'b0, 1'b0);
        send_byte(8'h22, 1'b0, 1'b0);
        check("busy_mid_word", 32'(busy), 32'd1);
        do_reset();
        send_byte(8'h01, 1'b0, 1'b0);
        send_byte(8'h00, 1'b0, 1'b0);
        send_byte(8'hAA, 1'b0, 1'b0);
        send_byte(8'hBB, 1'b0, 1'b0);
        send_byte(8'hCC, 1'b0, 1'b0);
        send_byte(8'hDD, 1'b0, 1'b0);
        idle(1'b0);
        check_done(1);
        if (seen_q.size() == 1) begin
            check("rst_mid_addr", seen_q[0].addr, 32'h0);
            check("rst_mid_data", seen_q[0].data, 32'hDDCCBBAA);
        end

        // Reset while the write strobe is high must drop it at once
        do_reset();
        send_byte(8'h01, 1'b0, 1'b0);
        send_byte(8'h00, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) send_byte(8'(k + 1), 1'b0, 1'b0);
        check("we_before_rst", 32'(we), 32'd1);
        do_reset();

        // Full-depth load
        do_reset();
        send_byte(8'h00, 1'b0, 1'b0);
        send_byte(8'h04, 1'b0, 1'b0);
        check("full_no_error", 32'(error), 32'd0);
        for (int w = 0; w < DEPTH; w++)
            for (int k = 0; k < 4; k++)
                send_byte(8'($urandom_range(0, 255)), 1'b0, 1'b0);
        idle(1'b0);
        check_done(DEPTH);
        if (seen_q.size() == DEPTH)
            check("full_last_addr", seen_q[DEPTH-1].addr, 32'hFFC);
        idle(1'b1);
        check_rearmed();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no end of test expected finish before 5 ms");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, meaning instruction memory depth in 32-bit words.
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  single-cycle pulse that re-arms the loader from DONE or ERR.
REQ-005 SHALL have port in_valid  input  1  byte available on in_byte.
REQ-006 SHALL have port in_byte  input  8  program stream byte.
REQ-007 SHALL have port in_ready  output  1  loader accepts in_byte this cycle.
REQ-008 SHALL have port we  output  1  one-cycle instruction-memory write strobe.
REQ-009 SHALL have port waddr  output  32  byte address of the write, word-aligned (bits [1:0] = 0).
REQ-010 SHALL have port wdata  output  32  instruction word to write.
REQ-011 SHALL have port busy  output  1  a load is in progress.
REQ-012 SHALL have port done  output  1  all announced words written.
REQ-013 SHALL have port error  output  1  the header word count is illegal.

Function
REQ-014 SHALL transfer a byte only in a cycle where in_valid and in_ready are both 1.
- in_byte SHALL be ignored otherwise.
REQ-015 SHALL define the stream format as follows:
- 2-byte header N, little-endian, the word count.
- Then N words of 4 bytes each, little-endian: the first byte is wdata[7:0].
REQ-016 SHALL implement states HDR0, HDR1, DATA, WRITE, DONE, ERR, with reset state HDR0.
REQ-017 SHALL transition HDR0 to HDR1 on a transfer, capturing N[7:0].
REQ-018 SHALL leave HDR1 on a transfer, capturing N[15:8], as follows:
- If N is 0 or N > DEPTH: go to ERR.
- Otherwise: go to DATA with the word index at 0 and the byte counter at 0.
REQ-019 SHALL behave in DATA as follows:
- Each transfer shifts the byte into the assembly register and increments the 2-bit byte counter.
- The transfer with byte counter = 3 goes to WRITE.
REQ-020 SHALL behave in WRITE for exactly one cycle as follows:
- we = 1, waddr = index*4, wdata = the assembled word.
- Then increment the index.
- Go to DONE if the index now equals N, else go to DATA.
REQ-021 SHALL hold in_ready = 1 only in HDR0, HDR1 and DATA.
REQ-022 SHALL give a latency of exactly one cycle from the fourth byte's transfer edge to the cycle with we = 1.
REQ-023 SHALL hold busy = 1 in HDR1, DATA and WRITE.
- busy SHALL be 0 in HDR0, so the bus looks idle until the first header byte arrives.
REQ-024 SHALL hold done = 1 only in DONE and error = 1 only in ERR; both are level outputs.
REQ-025 SHALL, on a start pulse in DONE or ERR, go to HDR0 and clear the index.
- start SHALL be ignored in all other states.
REQ-026 SHALL, when N = DEPTH, write the last word at waddr = (DEPTH-1)*4.
- The index SHALL never wrap.
REQ-027 SHALL keep we, waddr and wdata at 0 in every cycle outside WRITE.
REQ-028 SHALL size the index as a register wide enough to hold DEPTH, with no truncation on the comparison with N.

Reset
REQ-029 SHALL, while rst = 1, immediately force the following, independent of clk:
- State = HDR0.
- in_ready = 0, we = 0, waddr = 0, wdata = 0.
- busy = 0, done = 0, error = 0.
- Index, N and byte counter = 0.
REQ-030 SHALL discard any partial word or header on reset mid-load.
- No write SHALL be issued for a partial word.
REQ-031 SHALL raise in_ready on the first rising clk edge after rst deasserts.

Structure
REQ-032 SHALL place the state encodings, the default DEPTH and the header width (16) in the shared MIPS constants package/include.
- The same DEPTH SHALL also size the instruction memory.
REQ-033 SHALL contain one sub-module, byte_packer:
- It holds the 2-bit byte counter and the 32-bit shift-assembly register.
- Its outputs are word and word_complete.
REQ-034 SHALL connect to the write port of the instruction memory directly, with no extra pipeline stage.

Verification
REQ-035 SHALL cover the nominal load: stream 02 00 | 20 08 00 05 | 00 00 00 08.
- Required: we pulses twice, waddr=0x0 with wdata=0x05000820, then waddr=0x4 with wdata=0x08000000.
- Then done=1 and in_ready=0.
REQ-036 SHALL cover the illegal count: header 00 00 -> error=1 the cycle after the second byte, no we.
- Also: header 01 04 (N=1025) -> error=1, no we.
REQ-037 SHALL cover backpressure and gaps: in_valid toggled randomly during the nominal stream.
- Required: identical writes and the one-cycle WRITE latency counted from the fourth accepted byte.
- in_ready = 0 during the WRITE cycle.
REQ-038 SHALL cover reset mid-word: rst asserted after 2 data bytes.
- Required: all outputs go to 0 asynchronously.
- A fresh stream 01 00 AA BB CC DD then writes 0xDDCCBBAA at waddr=0x0.
REQ-039 SHALL cover the full-depth boundary: N = DEPTH = 1024 (header 00 04).
- Required: 1024 writes, last waddr=0xFFC, then done=1.
- A start pulse then returns the loader to HDR0.
REQ-040 SHALL cover start mid-load: start pulsed in DATA -> ignored, and the load completes normally.
